riscv_mc_ctrl: RTL and testbench

RISCV_MC_CTRL -- requirements
Module: riscv_mc_ctrl

---
 rtl/riscv_ctrl_pkg.sv | 68 ++++++
 rtl/riscv_mc_ctrl_if.sv | 10 +
 rtl/ctrl_decode.sv | 74 +++++++
 rtl/riscv_mc_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control unit.
// Optional trap behaviour is selected in the top by CTRL_TRAP_EN.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExec    = 4'd2,
    StMemAddr = 4'd3,
    StMemRd   = 4'd4,
    StMemWr   = 4'd5,
    StWb      = 4'd6,
    StBranch  = 4'd7,
    StJump    = 4'd8,
    StTrap    = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    ClsAlu, ClsAluImm, ClsLui, ClsAuipc, ClsLoad, ClsStore,
    ClsBranch, ClsJal, ClsJalr, ClsIllegal
  } cls_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmU = 3'b010;
  localparam logic [2:0] ImmB = 3'b101;
  localparam logic [2:0] ImmJ = 3'b110;

  // ALU op code is {funct7[5], funct3}.
  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b1000;
  localparam logic [3:0] AluSlt  = 4'b0010;
  localparam logic [3:0] AluSltu = 4'b0011;

  localparam logic [1:0] PcSrcPlus4 = 2'b00;
  localparam logic [1:0] PcSrcAlu   = 2'b01;
  localparam logic [1:0] PcSrcJalr  = 2'b10;

  localparam logic [1:0] ResAlu = 2'b00;
  localparam logic [1:0] ResMem = 2'b01;
  localparam logic [1:0] ResPc4 = 2'b10;

  localparam logic [1:0] AluARs1  = 2'b00;
  localparam logic [1:0] AluAPc   = 2'b01;
  localparam logic [1:0] AluAZero = 2'b10;
  localparam logic [1:0] AluBRs2  = 2'b00;
  localparam logic [1:0] AluBImm  = 2'b01;
  localparam logic [1:0] AluBFour = 2'b10;

  // funct3[2] picks the lt flag over zero; funct3[0] inverts the condition.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic lt);
    logic cond;
    cond = funct3[2] ? lt : zero;
    return cond ^ funct3[0];
  endfunction

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// Memory handshake between the control unit (master) and the memory (slave).
interface riscv_mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_err;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_err, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_err, output mem_ready);
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decode: instruction class, immediate select,
// ALU operation and illegal-instruction flag.
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output cls_e        cls_o,
  output logic [2:0]  imm_src_o,
  output logic [3:0]  alu_ctrl_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       unused_instr;

  assign opcode       = instr_i[6:0];
  assign funct3       = instr_i[14:12];
  assign funct7_b5    = instr_i[30];
  assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  always_comb begin
    cls_o      = ClsIllegal;
    imm_src_o  = ImmI;
    alu_ctrl_o = AluAdd;
    illegal_o  = 1'b0;
    case (opcode)
      OpOp: begin
        cls_o      = ClsAlu;
        alu_ctrl_o = {funct7_b5 & (funct3 == 3'b000 || funct3 == 3'b101), funct3};
      end
      OpImm: begin
        // Only SRAI uses funct7[5]; for ADDI it is an immediate bit.
        cls_o      = ClsAluImm;
        alu_ctrl_o = {funct7_b5 & (funct3 == 3'b101), funct3};
      end
      OpLoad: begin
        cls_o     = ClsLoad;
        illegal_o = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OpStore: begin
        cls_o     = ClsStore;
        imm_src_o = ImmS;
        illegal_o = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OpBranch: begin
        cls_o      = ClsBranch;
        imm_src_o  = ImmB;
        illegal_o  = (funct3[2:1] == 2'b01);
        alu_ctrl_o = funct3[2] ? (funct3[1] ? AluSltu : AluSlt) : AluSub;
      end
      OpJal: begin
        cls_o     = ClsJal;
        imm_src_o = ImmJ;
      end
      OpJalr: begin
        cls_o     = ClsJalr;
        illegal_o = (funct3 != 3'b000);
      end
      OpLui: begin
        cls_o     = ClsLui;
        imm_src_o = ImmU;
      end
      OpAuipc: begin
        cls_o     = ClsAuipc;
        imm_src_o = ImmU;
      end
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) cls_o = ClsIllegal;
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RISC-V control FSM with memory wait timeout.
// Define CTRL_TRAP_EN to trap on illegal instructions instead of treating them as NOPs.
module riscv_mc_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  riscv_mc_ctrl_if.master        mem,
  input  logic [31:0]            instr,
  input  logic                   alu_zero,
  input  logic                   alu_lt,
  output logic                   ir_we,
  output logic                   pc_we,
  output logic                   reg_we,
  output logic [1:0]             pc_src,
  output logic [2:0]             imm_src,
  output logic [1:0]             alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [3:0]             alu_ctrl,
  output logic [1:0]             result_src,
  output logic                   trap,
  output logic [3:0]             state_o
);

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       run_q, run_d;
  logic       req_c, we_c, err_c, timeout;
  cls_e       dec_cls;
  logic [2:0] dec_imm;
  logic [3:0] dec_alu;
  logic       dec_illegal;

  ctrl_decode u_decode (
    .instr_i    (instr),
    .cls_o      (dec_cls),
    .imm_src_o  (dec_imm),
    .alu_ctrl_o (dec_alu),
    .illegal_o  (dec_illegal)
  );

  // run_q holds every output low for the cycle in which reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    run_d      = 1'b1;
    req_c      = 1'b0;
    we_c       = 1'b0;
    err_c      = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    pc_src     = PcSrcPlus4;
    imm_src    = ImmI;
    alu_src_a  = AluARs1;
    alu_src_b  = AluBRs2;
    alu_ctrl   = AluAdd;
    result_src = ResAlu;
    timeout    = (cnt_q == TimeoutCnt);

    if (run_q) begin
      if (state_q != StFetch && state_q != StTrap) imm_src = dec_imm;
      case (state_q)
        StFetch: begin
          alu_src_a = AluAPc;
          alu_src_b = AluBFour;
          if (timeout) begin
            err_c = 1'b1;
          end else begin
            req_c = 1'b1;
            if (mem.mem_ready) begin
              ir_we   = 1'b1;
              pc_we   = 1'b1;
              state_d = StDecode;
            end
          end
        end
        StDecode: begin
          alu_src_a = AluAPc;
          alu_src_b = AluBImm;
          if (dec_illegal) begin
`ifdef CTRL_TRAP_EN
            state_d = StTrap;
`else
            state_d = StFetch;
`endif
          end else begin
            case (dec_cls)
              ClsLoad, ClsStore: state_d = StMemAddr;
              ClsBranch:         state_d = StBranch;
              ClsJal, ClsJalr:   state_d = StJump;
              default:           state_d = StExec;
            endcase
          end
        end
        StExec: begin
          alu_ctrl  = dec_alu;
          alu_src_b = AluBImm;
          case (dec_cls)
            ClsAlu:   alu_src_b = AluBRs2;
            ClsLui:   alu_src_a = AluAZero;
            ClsAuipc: alu_src_a = AluAPc;
            default:  alu_src_a = AluARs1;
          endcase
          state_d = StWb;
        end
        StMemAddr: begin
          alu_src_b = AluBImm;
          state_d   = (dec_cls == ClsStore) ? StMemWr : StMemRd;
        end
        StMemRd: begin
          result_src = ResMem;
          if (timeout) begin
            err_c   = 1'b1;
            state_d = StFetch;
          end else begin
            req_c = 1'b1;
            if (mem.mem_ready) state_d = StWb;
          end
        end
        StMemWr: begin
          if (timeout) begin
            err_c   = 1'b1;
            state_d = StFetch;
          end else begin
            req_c = 1'b1;
            we_c  = 1'b1;
            if (mem.mem_ready) state_d = StFetch;
          end
        end
        StWb: begin
          reg_we     = 1'b1;
          result_src = (dec_cls == ClsLoad) ? ResMem : ResAlu;
          state_d    = StFetch;
        end
        StBranch: begin
          alu_ctrl = dec_alu;
          if (branch_taken(instr[14:12], alu_zero, alu_lt)) begin
            pc_we  = 1'b1;
            pc_src = PcSrcAlu;
          end
          state_d = StFetch;
        end
        StJump: begin
          pc_we      = 1'b1;
          reg_we     = 1'b1;
          result_src = ResPc4;
          alu_src_b  = AluBImm;
          if (dec_cls == ClsJalr) begin
            pc_src = PcSrcJalr;
          end else begin
            pc_src    = PcSrcAlu;
            alu_src_a = AluAPc;
          end
          state_d = StFetch;
        end
`ifdef CTRL_TRAP_EN
        StTrap: state_d = StTrap;
`endif
        default: state_d = StFetch;
      endcase
    end

    // Wait counter restarts on any state change or after a timeout.
    if (err_c || state_d != state_q) begin
      cnt_d = '0;
    end else if (req_c && !mem.mem_ready) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign mem.mem_req = req_c;
  assign mem.mem_we  = we_c;
  assign mem.mem_err = err_c;
  assign state_o     = state_q;

`ifdef CTRL_TRAP_EN
  assign trap = run_q && (state_q == StTrap);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed self-checking bench for riscv_mc_ctrl (honours CTRL_TRAP_EN).
module tb_riscv_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        alu_zero = 1'b0;
  logic        alu_lt = 1'b0;
  logic        ir_we, pc_we, reg_we, trap;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, result_src;
  logic [2:0]  imm_src;
  logic [3:0]  alu_ctrl, state_o;

  int checks = 0;
  int errors = 0;

  riscv_mc_ctrl_if bus ();

  riscv_mc_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (bus.master),
    .instr      (instr),
    .alu_zero   (alu_zero),
    .alu_lt     (alu_lt),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .reg_we     (reg_we),
    .pc_src     (pc_src),
    .imm_src    (imm_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .result_src (result_src),
    .trap       (trap),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // en order: mem_req, mem_we, mem_err, ir_we, pc_we, reg_we, trap
  logic [17:0] obs, exp_v;
  assign obs = {state_o, bus.mem_req, bus.mem_we, bus.mem_err, ir_we, pc_we, reg_we, trap,
                pc_src, imm_src, result_src};

  function automatic logic [17:0] ev(input logic [3:0] st, input logic [6:0] en,
                                     input logic [1:0] pcs, input logic [2:0] imm,
                                     input logic [1:0] res);
    return {st, en, pcs, imm, res};
  endfunction

  // EXEC-stage expectations: {alu_src_a, alu_src_b, alu_ctrl}, imm_src
  logic [31:0] alu_ins [6] = '{32'h00500093, 32'h40000093, 32'h40208033,
                               32'h4030D093, 32'h123450B7, 32'h00001097};
  logic [7:0]  alu_exp [6] = '{8'b00_01_0000, 8'b00_01_0000, 8'b00_00_1000,
                               8'b00_01_1101, 8'b10_01_0000, 8'b01_01_0000};
  logic [2:0]  alu_imm [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010};

  logic [2:0]  br_f3  [6] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101, 3'b110};
  logic        br_z   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        br_lt  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic        br_tk  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0]  br_alu [6] = '{4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0010, 4'b0011};

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns after the negedge of the first FETCH cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== 18'h0 || {alu_src_a, alu_src_b, alu_ctrl} !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs obs=%h alu=%h want 0", obs, {alu_src_a, alu_src_b, alu_ctrl});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 18'h0) begin
      errors++;
      $display("FAIL reset_release_idle obs=%h want 0", obs);
    end
    bus.mem_ready = 1'b0;
    next_cycle();
    exp_v = ev(4'd0, 7'b1000000, 2'b00, 3'b000, 2'b00);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_first_req obs=%h want %h", obs, exp_v);
    end
  endtask

  task automatic test_alu();
    for (int i = 0; i < 6; i++) begin
      instr = alu_ins[i];
      bus.mem_ready = 1'b1;
      #1;
      exp_v = ev(4'd0, 7'b1001100, 2'b00, 3'b000, 2'b00);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL alu%0d_fetch obs=%h want %h", i, obs, exp_v);
      end
      next_cycle();
      exp_v = ev(4'd1, 7'b0000000, 2'b00, alu_imm[i], 2'b00);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL alu%0d_decode obs=%h want %h", i, obs, exp_v);
      end
      next_cycle();
      exp_v = ev(4'd2, 7'b0000000, 2'b00, alu_imm[i], 2'b00);
      checks++;
      if (obs !== exp_v || {alu_src_a, alu_src_b, alu_ctrl} !== alu_exp[i]) begin
        errors++;
        $display("FAIL alu%0d_exec obs=%h alu=%b want %h alu=%b", i, obs,
                 {alu_src_a, alu_src_b, alu_ctrl}, exp_v, alu_exp[i]);
      end
      next_cycle();
      exp_v = ev(4'd6, 7'b0000010, 2'b00, alu_imm[i], 2'b00);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL alu%0d_wb obs=%h want %h", i, obs, exp_v);
      end
      next_cycle();
      checks++;
      if (state_o !== 4'd0) begin
        errors++;
        $display("FAIL alu%0d_latency state=%0d want 0", i, state_o);
      end
    end
  endtask

  task automatic test_load();
    instr = 32'h0080A283;
    bus.mem_ready = 1'b1;
    #1;
    next_cycle();
    next_cycle();
    exp_v = ev(4'd3, 7'b0000000, 2'b00, 3'b000, 2'b00);
    checks++;
    if (obs !== exp_v || alu_src_b !== 2'b01) begin
      errors++;
      $display("FAIL lw_memaddr obs=%h srcb=%b want %h srcb=01", obs, alu_src_b, exp_v);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.mem_ready = (i == 3);
      #1;
      exp_v = ev(4'd4, 7'b1000000, 2'b00, 3'b000, 2'b01);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL lw_memrd%0d obs=%h want %h", i, obs, exp_v);
      end
    end
    next_cycle();
    exp_v = ev(4'd6, 7'b0000010, 2'b00, 3'b000, 2'b01);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL lw_wb obs=%h want %h", obs, exp_v);
    end
    next_cycle();
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL lw_latency state=%0d want 0", state_o);
    end
  endtask

  task automatic test_store();
    instr = 32'h0020A223;
    bus.mem_ready = 1'b1;
    #1;
    next_cycle();
    exp_v = ev(4'd1, 7'b0000000, 2'b00, 3'b001, 2'b00);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL sw_decode obs=%h want %h", obs, exp_v);
    end
    next_cycle();
    next_cycle();
    exp_v = ev(4'd5, 7'b1100000, 2'b00, 3'b001, 2'b00);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL sw_memwr obs=%h want %h", obs, exp_v);
    end
    next_cycle();
    checks++;
    if (state_o !== 4'd0 || reg_we !== 1'b0) begin
      errors++;
      $display("FAIL sw_latency state=%0d reg_we=%b want 0 0", state_o, reg_we);
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 6; i++) begin
      instr = 32'h00208463 | (32'(br_f3[i]) << 12);
      alu_zero = br_z[i];
      alu_lt = br_lt[i];
      bus.mem_ready = 1'b1;
      #1;
      next_cycle();
      next_cycle();
      exp_v = ev(4'd7, br_tk[i] ? 7'b0000100 : 7'b0000000, br_tk[i] ? 2'b01 : 2'b00,
                 3'b101, 2'b00);
      checks++;
      if (obs !== exp_v || alu_ctrl !== br_alu[i]) begin
        errors++;
        $display("FAIL br%0d obs=%h alu=%b want %h alu=%b", i, obs, alu_ctrl, exp_v, br_alu[i]);
      end
      next_cycle();
      checks++;
      if (state_o !== 4'd0) begin
        errors++;
        $display("FAIL br%0d_latency state=%0d want 0", i, state_o);
      end
    end
  endtask

  task automatic test_jump();
    instr = 32'h010000EF;
    bus.mem_ready = 1'b1;
    #1;
    next_cycle();
    next_cycle();
    exp_v = ev(4'd8, 7'b0000110, 2'b01, 3'b110, 2'b10);
    checks++;
    if (obs !== exp_v || alu_src_a !== 2'b01) begin
      errors++;
      $display("FAIL jal obs=%h srca=%b want %h srca=01", obs, alu_src_a, exp_v);
    end
    next_cycle();
    instr = 32'h000100E7;
    #1;
    next_cycle();
    next_cycle();
    exp_v = ev(4'd8, 7'b0000110, 2'b10, 3'b000, 2'b10);
    checks++;
    if (obs !== exp_v || alu_src_a !== 2'b00) begin
      errors++;
      $display("FAIL jalr obs=%h srca=%b want %h srca=00", obs, alu_src_a, exp_v);
    end
    next_cycle();
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL jalr_latency state=%0d want 0", state_o);
    end
  endtask

  task automatic test_timeout();
    instr = 32'h00500093;
    bus.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      exp_v = ev(4'd0, 7'b1000000, 2'b00, 3'b000, 2'b00);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL tmo_wait%0d obs=%h want %h", i, obs, exp_v);
      end
      next_cycle();
    end
    // Ready during the error cycle must be ignored since no request is open.
    bus.mem_ready = 1'b1;
    #1;
    exp_v = ev(4'd0, 7'b0010000, 2'b00, 3'b000, 2'b00);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL tmo_err obs=%h want %h", obs, exp_v);
    end
    next_cycle();
    exp_v = ev(4'd0, 7'b1001100, 2'b00, 3'b000, 2'b00);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL tmo_refetch obs=%h want %h", obs, exp_v);
    end
    repeat (4) next_cycle();
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL tmo_resume state=%0d want 0", state_o);
    end
  endtask

  task automatic test_reset_mem_wr();
    instr = 32'h0020A223;
    bus.mem_ready = 1'b1;
    #1;
    next_cycle();
    next_cycle();
    bus.mem_ready = 1'b0;
    next_cycle();
    exp_v = ev(4'd5, 7'b1100000, 2'b00, 3'b001, 2'b00);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rstwr_memwr obs=%h want %h", obs, exp_v);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 18'h0) begin
      errors++;
      $display("FAIL rstwr_async obs=%h want 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    exp_v = ev(4'd0, 7'b1000000, 2'b00, 3'b000, 2'b00);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rstwr_refetch obs=%h want %h", obs, exp_v);
    end
  endtask

  task automatic test_illegal(input logic [31:0] ins, input int id);
    instr = ins;
    bus.mem_ready = 1'b1;
    #1;
    next_cycle();
    exp_v = ev(4'd1, 7'b0000000, 2'b00, 3'b000, 2'b00);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ill%0d_decode obs=%h want %h", id, obs, exp_v);
    end
`ifdef CTRL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      exp_v = ev(4'd9, 7'b0000001, 2'b00, 3'b000, 2'b00);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ill%0d_trap%0d obs=%h want %h", id, i, obs, exp_v);
      end
    end
    do_reset();
`else
    next_cycle();
    exp_v = ev(4'd0, 7'b1001100, 2'b00, 3'b000, 2'b00);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ill%0d_nop obs=%h want %h", id, obs, exp_v);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_ready = 1'b0;
    do_reset();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_jump();
    test_timeout();
    test_reset_mem_wr();
    test_illegal(32'h0000007F, 0);
    test_illegal(32'h000110E7, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
